seq_hit_tracker: RTL and testbench

Downstream consumer of the 11011 overlapping Mealy detector: samples its one-cycle `out` pulse (wired to `hit`) on every serial bit and timestamps each detection by its distance in bits from the previous one. It keeps a saturating hit count and raises sticky flags for closely spaced (overlapping) hits and for lost reports. Each detection is presented as a report on a valid/ready handshake to the logging/CPU side.

---
 rtl/seq_hit_tracker.sv | 123 ++++++++++++
 tb/tb_seq_hit_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_tracker.sv
// seq_hit_tracker: timestamps each 11011 detector hit by its distance in
// serial bits from the previous hit. It keeps a saturating hit count and
// sticky burst/drop flags, and presents every hit as a valid/ready report.
module seq_hit_tracker #(
   parameter int unsigned GW      = 8,
   parameter int unsigned CW      = 16,
   parameter int unsigned MIN_GAP = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bit_en,
   input  logic          hit,
   input  logic          clr,
   input  logic          rep_ready,
   output logic          rep_valid,
   output logic [GW-1:0] rep_gap,
   output logic [CW-1:0] rep_idx,
   output logic [CW-1:0] hit_count,
   output logic          burst,
   output logic          drop
);

   localparam logic ST_IDLE  = 1'b0;  // no hit seen since reset
   localparam logic ST_TRACK = 1'b1;  // at least one hit seen

   localparam logic [GW-1:0] MIN_GAP_W = GW'(MIN_GAP);

   logic          state_q,     state_d;
   logic [GW-1:0] gap_q,       gap_d;
   logic          rep_valid_q, rep_valid_d;
   logic [GW-1:0] rep_gap_q,   rep_gap_d;
   logic [CW-1:0] rep_idx_q,   rep_idx_d;
   logic [CW-1:0] hit_count_q, hit_count_d;
   logic          burst_q,     burst_d;
   logic          drop_q,      drop_d;

   logic          qhit;
   logic          load;
   logic          close_hit;
   logic [GW-1:0] hit_gap;
   logic [CW-1:0] cnt_base;
   logic [CW-1:0] cnt_inc;

   // Gap tracking, statistics and report handshake next-state logic
   always_comb begin
      qhit      = bit_en & hit;
      state_d   = state_q;
      gap_d     = gap_q;

      // Gap to report: zero for the first hit after reset
      hit_gap   = (state_q == ST_TRACK) ? gap_q : '0;
      close_hit = qhit && (state_q == ST_TRACK) && (gap_q < MIN_GAP_W);

      if (bit_en) begin
         case (state_q)
            ST_IDLE: begin
               if (hit) begin
                  state_d = ST_TRACK;
                  gap_d   = GW'(1);
               end
            end
            default: begin
               if (hit) begin
                  gap_d = GW'(1);
               end else if (gap_q != '1) begin
                  gap_d = gap_q + GW'(1);
               end
            end
         endcase
      end

      // Clear applies first, so a hit in the clear cycle counts as the first
      cnt_base    = clr ? '0 : hit_count_q;
      cnt_inc     = (cnt_base == '1) ? cnt_base : cnt_base + CW'(1);
      hit_count_d = qhit ? cnt_inc : cnt_base;

      load    = qhit && (!rep_valid_q || rep_ready);
      burst_d = (clr ? 1'b0 : burst_q) | close_hit;
      drop_d  = (clr ? 1'b0 : drop_q) | (qhit && rep_valid_q && !rep_ready);

      rep_valid_d = rep_valid_q;
      rep_gap_d   = rep_gap_q;
      rep_idx_d   = rep_idx_q;
      if (load) begin
         rep_valid_d = 1'b1;
         rep_gap_d   = hit_gap;
         rep_idx_d   = cnt_inc;
      end else if (rep_valid_q && rep_ready) begin
         rep_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gap_q       <= '0;
         rep_valid_q <= 1'b0;
         rep_gap_q   <= '0;
         rep_idx_q   <= '0;
         hit_count_q <= '0;
         burst_q     <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         rep_valid_q <= rep_valid_d;
         rep_gap_q   <= rep_gap_d;
         rep_idx_q   <= rep_idx_d;
         hit_count_q <= hit_count_d;
         burst_q     <= burst_d;
         drop_q      <= drop_d;
      end
   end

   assign rep_valid = rep_valid_q;
   assign rep_gap   = rep_gap_q;
   assign rep_idx   = rep_idx_q;
   assign hit_count = hit_count_q;
   assign burst     = burst_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_seq_hit_tracker.sv
// Directed bench for seq_hit_tracker: reset, overlapping and spaced hits,
// backpressure/drop, gap saturation with bit_en gaps, clear and reset.
module tb_seq_hit_tracker;

   logic        clk = 1'b0;
   logic        rst, bit_en, hit, clr, rep_ready;
   logic        rep_valid, burst, drop;
   logic [7:0]  rep_gap;
   logic [15:0] rep_idx, hit_count;

   int checks = 0;
   int errors = 0;

   seq_hit_tracker #(.GW(8), .CW(16), .MIN_GAP(5)) dut (
      .clk(clk), .rst(rst), .bit_en(bit_en), .hit(hit), .clr(clr),
      .rep_ready(rep_ready), .rep_valid(rep_valid), .rep_gap(rep_gap),
      .rep_idx(rep_idx), .hit_count(hit_count), .burst(burst), .drop(drop)
   );

   always #5 clk = ~clk;

   // Drive one cycle's bit/hit, then sample 1 time unit after the edge
   task automatic step(input logic en, input logic h);
      bit_en = en;
      hit    = h;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; rep_ready = 1'b1;
      step(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; rep_ready = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      checks++; if (rep_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", rep_valid); end
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL rst_gap got %0d exp 0", rep_gap); end
      checks++; if (rep_idx !== 16'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", rep_idx); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", hit_count); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL rst_burst got %0d exp 0", burst); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop); end
      rst = 1'b0;
      repeat (3) step(1'b1, 1'b0);
      checks++; if (rep_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0d exp 0", rep_valid); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL idle_count got %0d exp 0", hit_count); end
   endtask

   // Stream 11011011: detector hits at bits 5 and 8
   task automatic test_overlap();
      do_reset();
      rep_ready = 1'b1;
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1);                    // bit 5
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL ov_valid1 got %0d exp 1", rep_valid); end
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL ov_gap1 got %0d exp 0", rep_gap); end
      checks++; if (rep_idx !== 16'd1) begin errors++; $display("FAIL ov_idx1 got %0d exp 1", rep_idx); end
      step(1'b1, 1'b0);                    // bit 6, report consumed
      checks++; if (rep_valid !== 1'b0) begin errors++; $display("FAIL ov_consumed got %0d exp 0", rep_valid); end
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);                    // bit 8
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL ov_valid2 got %0d exp 1", rep_valid); end
      checks++; if (rep_gap !== 8'd3) begin errors++; $display("FAIL ov_gap2 got %0d exp 3", rep_gap); end
      checks++; if (rep_idx !== 16'd2) begin errors++; $display("FAIL ov_idx2 got %0d exp 2", rep_idx); end
      checks++; if (burst !== 1'b1) begin errors++; $display("FAIL ov_burst got %0d exp 1", burst); end
      checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL ov_count got %0d exp 2", hit_count); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL ov_drop got %0d exp 0", drop); end
   endtask

   // Stream 1101111011: hits at bits 5 and 10
   task automatic test_nonoverlap();
      do_reset();
      rep_ready = 1'b1;
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL no_gap1 got %0d exp 0", rep_gap); end
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      checks++; if (rep_gap !== 8'd5) begin errors++; $display("FAIL no_gap2 got %0d exp 5", rep_gap); end
      checks++; if (rep_idx !== 16'd2) begin errors++; $display("FAIL no_idx2 got %0d exp 2", rep_idx); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL no_burst got %0d exp 0", burst); end
   endtask

   task automatic test_backpressure();
      do_reset();
      rep_ready = 1'b0;
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1);                    // bit 5 loads
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL bp_drop_early got %0d exp 0", drop); end
      step(1'b1, 1'b1);                    // bit 8 dropped
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0d exp 1", rep_valid); end
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL bp_gap got %0d exp 0", rep_gap); end
      checks++; if (rep_idx !== 16'd1) begin errors++; $display("FAIL bp_idx got %0d exp 1", rep_idx); end
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop got %0d exp 1", drop); end
      checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", hit_count); end
      checks++; if (burst !== 1'b1) begin errors++; $display("FAIL bp_burst got %0d exp 1", burst); end
      // Clear with no hit: statistics only, pending report untouched
      clr = 1'b1;
      step(1'b0, 1'b0);
      clr = 1'b0;
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL clr_drop got %0d exp 0", drop); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", hit_count); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL clr_burst got %0d exp 0", burst); end
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got %0d exp 1", rep_valid); end
      checks++; if (rep_idx !== 16'd1) begin errors++; $display("FAIL clr_idx got %0d exp 1", rep_idx); end
      rep_ready = 1'b1;
      step(1'b1, 1'b0);
      rep_ready = 1'b0;
      checks++; if (rep_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %0d exp 0", rep_valid); end
   endtask

   task automatic test_saturation();
      do_reset();
      rep_ready = 1'b1;
      step(1'b1, 1'b1);
      // 100 empty bits, each followed by an ignored bit_en=0 cycle with hit=1
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b1);
      end
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL sat_gated_count got %0d exp 1", hit_count); end
      step(1'b1, 1'b1);
      checks++; if (rep_gap !== 8'd101) begin errors++; $display("FAIL sat_gap101 got %0d exp 101", rep_gap); end
      checks++; if (rep_idx !== 16'd2) begin errors++; $display("FAIL sat_idx2 got %0d exp 2", rep_idx); end
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0);
         if (i % 3 == 0) step(1'b0, 1'b0);
      end
      step(1'b1, 1'b1);
      checks++; if (rep_gap !== 8'd255) begin errors++; $display("FAIL sat_gap255 got %0d exp 255", rep_gap); end
      checks++; if (rep_idx !== 16'd3) begin errors++; $display("FAIL sat_idx3 got %0d exp 3", rep_idx); end
      checks++; if (hit_count !== 16'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", hit_count); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL sat_burst got %0d exp 0", burst); end
   endtask

   // Seven consecutive hits stream back-to-back reports (gap 1 each)
   task automatic test_back_to_back();
      do_reset();
      rep_ready = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0d exp 1", rep_valid); end
      checks++; if (rep_gap !== 8'd1) begin errors++; $display("FAIL b2b_gap got %0d exp 1", rep_gap); end
      checks++; if (rep_idx !== 16'd2) begin errors++; $display("FAIL b2b_idx got %0d exp 2", rep_idx); end
      repeat (5) step(1'b1, 1'b1);
      checks++; if (rep_idx !== 16'd7) begin errors++; $display("FAIL b2b_idx7 got %0d exp 7", rep_idx); end
      checks++; if (hit_count !== 16'd7) begin errors++; $display("FAIL b2b_count got %0d exp 7", hit_count); end
      checks++; if (burst !== 1'b1) begin errors++; $display("FAIL b2b_burst got %0d exp 1", burst); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop); end
   endtask

   // Continues from test_back_to_back: count 7, burst set
   task automatic test_clear_reset();
      repeat (9) step(1'b1, 1'b0);
      clr = 1'b1;
      step(1'b1, 1'b1);                    // 10 bits after previous hit
      clr = 1'b0;
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL clrhit_count got %0d exp 1", hit_count); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL clrhit_burst got %0d exp 0", burst); end
      checks++; if (rep_gap !== 8'd10) begin errors++; $display("FAIL clrhit_gap got %0d exp 10", rep_gap); end
      checks++; if (rep_idx !== 16'd1) begin errors++; $display("FAIL clrhit_idx got %0d exp 1", rep_idx); end
      checks++; if (rep_valid !== 1'b1) begin errors++; $display("FAIL clrhit_valid got %0d exp 1", rep_valid); end
      rep_ready = 1'b0;
      rst = 1'b1;
      step(1'b1, 1'b1);
      rst = 1'b0;
      checks++; if (rep_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got %0d exp 0", rep_valid); end
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL rst2_gap got %0d exp 0", rep_gap); end
      checks++; if (rep_idx !== 16'd0) begin errors++; $display("FAIL rst2_idx got %0d exp 0", rep_idx); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst2_count got %0d exp 0", hit_count); end
      checks++; if (burst !== 1'b0) begin errors++; $display("FAIL rst2_burst got %0d exp 0", burst); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst2_drop got %0d exp 0", drop); end
      // First hit after reset reports gap 0 again
      rep_ready = 1'b1;
      step(1'b1, 1'b1);
      checks++; if (rep_gap !== 8'd0) begin errors++; $display("FAIL rst2_first_gap got %0d exp 0", rep_gap); end
      checks++; if (rep_idx !== 16'd1) begin errors++; $display("FAIL rst2_first_idx got %0d exp 1", rep_idx); end
   endtask

   initial begin
      rst = 1'b1; bit_en = 1'b0; hit = 1'b0; clr = 1'b0; rep_ready = 1'b0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_backpressure();
      test_saturation();
      test_back_to_back();
      test_clear_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
